// File: rtl/robber_motion.sv
// robber_motion: per-player tile-hop movement controller for one robber.
// Each accepted keypress moves the sprite one 16 px tile, animated at STEP
// px per frame. A collision sends it back to spawn and freezes it for a
// respawn period. All outputs come straight from flops.
module robber_motion #(
    parameter int START_X        = 304,
    parameter int START_Y        = 448,
    parameter int STEP           = 2,
    parameter int MAX_X          = 624,
    parameter int MAX_Y          = 464,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       VS,
    input  logic       KeyUp,
    input  logic       KeyDown,
    input  logic       KeyLeft,
    input  logic       KeyRight,
    input  logic       Hit,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] Facing,
    output logic       Moving,
    output logic       Dead
);

    localparam logic [7:0]  HOP_TICKS = 8'(16 / STEP);
    localparam logic [10:0] MAX_X11   = 11'(MAX_X);
    localparam logic [10:0] MAX_Y11   = 11'(MAX_Y);
    localparam logic [9:0]  STEP10    = 10'(STEP);
    localparam logic [9:0]  START_X10 = 10'(START_X);
    localparam logic [9:0]  START_Y10 = 10'(START_Y);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_HOP, S_DEAD} state_t;

    state_t      state_q, state_d;
    logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]  facing_q, facing_d;
    logic        moving_q, moving_d, dead_q, dead_d;
    logic        armed_q, armed_d, vs_q, vs_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        tick, any_key, in_range;
    logic [1:0]  key_dir;
    logic [10:0] tgt_x, tgt_y;
    logic [9:0]  step_x, step_y;

    // Frame tick, key priority, target-tile bound check and per-frame step.
    // The target is computed 11 bits wide so a move below 0 shows up as a
    // large value rather than wrapping into range.
    always_comb begin
        tick    = VS & ~vs_q;
        any_key = KeyUp | KeyDown | KeyLeft | KeyRight;
        if (KeyUp)        key_dir = DIR_UP;
        else if (KeyDown) key_dir = DIR_DOWN;
        else if (KeyLeft) key_dir = DIR_LEFT;
        else              key_dir = DIR_RIGHT;

        tgt_x = {1'b0, pos_x_q};
        tgt_y = {1'b0, pos_y_q};
        case (key_dir)
            DIR_UP:   tgt_y = {1'b0, pos_y_q} - 11'd16;
            DIR_DOWN: tgt_y = {1'b0, pos_y_q} + 11'd16;
            DIR_LEFT: tgt_x = {1'b0, pos_x_q} - 11'd16;
            default:  tgt_x = {1'b0, pos_x_q} + 11'd16;
        endcase
        in_range = (tgt_x <= MAX_X11) && (tgt_y <= MAX_Y11);

        step_x = pos_x_q;
        step_y = pos_y_q;
        case (facing_q)
            DIR_UP:   step_y = pos_y_q - STEP10;
            DIR_DOWN: step_y = pos_y_q + STEP10;
            DIR_LEFT: step_x = pos_x_q - STEP10;
            default:  step_x = pos_x_q + STEP10;
        endcase
    end

    // Next-state logic: Hit outranks a tick on the same edge, and the
    // respawn freeze ignores both keys and further hits.
    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        facing_d = facing_q;
        moving_d = moving_q;
        dead_d   = dead_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        vs_d     = VS;
        case (state_q)
            S_IDLE, S_HOP: begin
                if (Hit) begin
                    state_d  = S_DEAD;
                    pos_x_d  = START_X10;
                    pos_y_d  = START_Y10;
                    facing_d = DIR_UP;
                    moving_d = 1'b0;
                    dead_d   = 1'b1;
                    armed_d  = 1'b0;
                    cnt_d    = 8'(RESPAWN_FRAMES);
                end else if (tick) begin
                    if (!any_key) armed_d = 1'b1;
                    if (state_q == S_IDLE) begin
                        if (armed_q && any_key) begin
                            facing_d = key_dir;
                            armed_d  = 1'b0;
                            if (in_range) begin
                                state_d  = S_HOP;
                                moving_d = 1'b1;
                                cnt_d    = 8'd0;
                            end
                        end
                    end else begin
                        pos_x_d = step_x;
                        pos_y_d = step_y;
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == HOP_TICKS) begin
                            state_d  = S_IDLE;
                            moving_d = 1'b0;
                            cnt_d    = 8'd0;
                        end
                    end
                end
            end
            default: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_IDLE;
                        dead_d  = 1'b0;
                        armed_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and output registers with asynchronous reset to the spawn tile.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            pos_x_q  <= START_X10;
            pos_y_q  <= START_Y10;
            facing_q <= DIR_UP;
            moving_q <= 1'b0;
            dead_q   <= 1'b0;
            armed_q  <= 1'b0;
            vs_q     <= 1'b1;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            facing_q <= facing_d;
            moving_q <= moving_d;
            dead_q   <= dead_d;
            armed_q  <= armed_d;
            vs_q     <= vs_d;
            cnt_q    <= cnt_d;
        end
    end

    assign PosX   = pos_x_q;
    assign PosY   = pos_y_q;
    assign Facing = facing_q;
    assign Moving = moving_q;
    assign Dead   = dead_q;

endmodule
